// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer.
// Op codes, FSM states and the packed FIFO entry layouts.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PASA = 4'h1;
    localparam logic [3:0] OP_PASB = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_ADD  = 4'hD;
    localparam logic [3:0] OP_SUB  = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    localparam int CMD_W = 70;
    localparam int RES_W = 69;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_RECOVER
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  shift;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    typedef struct packed {
        logic [3:0]  op;
        logic        err;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with a registered head entry and occupancy counter.
// Push while full is accepted only when a pop happens in the same cycle.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Head is loaded straight from din when the FIFO is (or becomes) empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if (do_push && (empty || (do_pop && count == CNT_ONE)))
                dout <= din;
            else if (do_pop && count > CNT_ONE)
                dout <= mem[rd_ptr + 1'b1];
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command-side ALU initiator: command FIFO -> ALU handshake FSM -> result FIFO.
// Handles MUL clear/start sequencing, done timeout and stale-done recovery.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [1:0]  cmd_shift,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic [3:0]  res_op,
    output logic        res_err,
    output logic [3:0]  alu_op_code,
    output logic [1:0]  alu_shift,
    output logic [31:0] alu_operand_1,
    output logic [31:0] alu_operand_2,
    output logic        alu_op_start,
    output logic        alu_op_clear,
    input  logic [31:0] alu_result_2,
    input  logic [31:0] alu_result_1,
    input  logic        alu_op_done,
    output logic        busy,
    output logic [15:0] issued_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    cmd_t    cmd_in;
    cmd_t    cmd_head;
    res_t    res_in;
    res_t    res_head;
    logic    cmd_empty;
    logic    cmd_full;
    logic    res_empty;
    logic    res_full;
    logic    cmd_pop;
    logic    res_push;
    logic    done_hit;
    logic    to_hit;
    state_t  state;
    logic    clr_cnt;
    logic [TW-1:0] tcnt;

    assign cmd_in = '{op: cmd_op, shift: cmd_shift, a: cmd_a, b: cmd_b};

    alu_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid && cmd_ready),
        .din     (cmd_in),
        .pop     (cmd_pop),
        .dout    (cmd_head),
        .empty   (cmd_empty),
        .full    (cmd_full)
    );

    alu_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (res_push),
        .din     (res_in),
        .pop     (res_ready),
        .dout    (res_head),
        .empty   (res_empty),
        .full    (res_full)
    );

    // The FSM is the only result producer, so a free slot at issue is kept
    assign cmd_pop  = (state == ST_IDLE) && !cmd_empty && !res_full;
    assign done_hit = (state == ST_START) && alu_op_done;
    assign to_hit   = (state == ST_START) && !alu_op_done && (tcnt == T_LAST);
    assign res_push = done_hit || to_hit;

    assign res_in = '{
        op:  alu_op_code,
        err: to_hit,
        hi:  done_hit ? alu_result_2 : 32'h0,
        lo:  done_hit ? alu_result_1 : 32'h0
    };

    assign cmd_ready = !cmd_full;
    assign res_valid = !res_empty;
    assign res_op    = res_head.op;
    assign res_err   = res_head.err;
    assign res_hi    = res_head.hi;
    assign res_lo    = res_head.lo;
    assign busy      = (state != ST_IDLE) || !cmd_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            clr_cnt       <= 1'b0;
            tcnt          <= '0;
            alu_op_code   <= '0;
            alu_shift     <= '0;
            alu_operand_1 <= '0;
            alu_operand_2 <= '0;
            alu_op_start  <= 1'b0;
            alu_op_clear  <= 1'b0;
            issued_cnt    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_pop) begin
                        alu_op_code   <= cmd_head.op;
                        alu_shift     <= cmd_head.shift;
                        alu_operand_1 <= cmd_head.a;
                        alu_operand_2 <= cmd_head.b;
                        tcnt          <= '0;
                        clr_cnt       <= 1'b0;
                        if (cmd_head.op == OP_MUL) begin
                            alu_op_clear <= 1'b1;
                            state        <= ST_CLEAR;
                        end else begin
                            alu_op_start <= 1'b1;
                            state        <= ST_START;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt) begin
                        alu_op_clear <= 1'b0;
                        alu_op_start <= 1'b1;
                        tcnt         <= '0;
                        state        <= ST_START;
                    end else begin
                        clr_cnt <= 1'b1;
                    end
                end
                ST_START: begin
                    if (res_push) begin
                        alu_op_start <= 1'b0;
                        alu_op_clear <= to_hit;
                        issued_cnt   <= issued_cnt + 16'd1;
                        state        <= ST_RECOVER;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RECOVER: begin
                    alu_op_clear <= 1'b0;
                    if (!alu_op_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU model.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [1:0]  cmd_shift = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [3:0]  res_op;
    logic        res_err;
    logic [3:0]  alu_op_code;
    logic [1:0]  alu_shift;
    logic [31:0] alu_operand_1;
    logic [31:0] alu_operand_2;
    logic        alu_op_start;
    logic        alu_op_clear;
    logic [31:0] alu_result_2;
    logic [31:0] alu_result_1;
    logic        alu_op_done;
    logic        busy;
    logic [15:0] issued_cnt;

    int vectors = 0;
    int errors = 0;

    bit hang = 1'b0;
    int extra = 0;
    int hold;
    int scnt;
    int lat;
    logic [63:0] r;

    alu_cmd_issuer #(
        .CMD_DEPTH (4),
        .RES_DEPTH (4),
        .TIMEOUT   (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_shift     (cmd_shift),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_hi        (res_hi),
        .res_lo        (res_lo),
        .res_op        (res_op),
        .res_err       (res_err),
        .alu_op_code   (alu_op_code),
        .alu_shift     (alu_shift),
        .alu_operand_1 (alu_operand_1),
        .alu_operand_2 (alu_operand_2),
        .alu_op_start  (alu_op_start),
        .alu_op_clear  (alu_op_clear),
        .alu_result_2  (alu_result_2),
        .alu_result_1  (alu_result_1),
        .alu_op_done   (alu_op_done),
        .busy          (busy),
        .issued_cnt    (issued_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        r = 64'h0;
        case (alu_op_code)
            4'h3: r = {32'h0, alu_operand_1 & alu_operand_2};
            4'h4: r = {32'h0, alu_operand_1 | alu_operand_2};
            4'h5: r = {32'h0, alu_operand_1 ^ alu_operand_2};
            4'hD: r = {32'h0, alu_operand_1 + alu_operand_2};
            4'hE: r = {32'h0, alu_operand_1 - alu_operand_2};
            4'hF: r = {32'h0, alu_operand_1} * {32'h0, alu_operand_2};
            default: r = 64'h0;
        endcase
    end
    assign alu_result_2 = r[63:32];
    assign alu_result_1 = r[31:0];
    assign lat = (alu_op_code == 4'hF) ? 3 : 1;

    // Done rises lat cycles after start, then lingers for 'extra' cycles
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt <= 0;
            hold <= 0;
            alu_op_done <= 1'b0;
        end else if (alu_op_start) begin
            scnt <= scnt + 1;
            if (!hang && scnt + 1 >= lat) begin
                alu_op_done <= 1'b1;
                hold <= extra;
            end
        end else begin
            scnt <= 0;
            if (hold > 0) begin
                hold <= hold - 1;
                alu_op_done <= 1'b1;
            end else begin
                alu_op_done <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int n = 0;
        cmd_op = op;
        cmd_shift = 2'd0;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200)
            chk("push_wait", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pop_chk(string tag, logic [3:0] op, logic err,
                           logic [31:0] hi, logic [31:0] lo);
        int n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, ".valid"}, 128'(res_valid), 128'(1'b1));
        chk(tag, 128'({res_op, res_err, res_hi, res_lo}), 128'({op, err, hi, lo}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst.cmd_ready", 128'(cmd_ready), 1);
        chk("rst.res", 128'({res_valid, res_op, res_err, res_hi, res_lo}), 0);
        chk("rst.alu", 128'({alu_op_code, alu_shift, alu_operand_1, alu_operand_2,
                             alu_op_start, alu_op_clear}), 0);
        chk("rst.busy_cnt", 128'({busy, issued_cnt}), 0);
        reset_n = 1'b1;
        tick();

        // Single-cycle ADD timeline
        push_cmd(4'hD, 32'h5, 32'h3);
        tick();
        chk("t1.start_e1", 128'(alu_op_start), 1);
        chk("t1.noval_e1", 128'(res_valid), 0);
        tick();
        tick();
        chk("t1.valid_e3", 128'(res_valid), 1);
        chk("t1.res", 128'({res_op, res_err, res_hi, res_lo}),
            128'({4'hD, 1'b0, 32'h0, 32'h8}));
        chk("t1.issued", 128'(issued_cnt), 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1.popped", 128'(res_valid), 0);
        repeat (3) tick();
        chk("t1.idle", 128'(busy), 0);

        // Back-pressure: four results fill the result FIFO, two commands wait
        push_cmd(4'h3, 32'hFF00FF00, 32'h0F0F0F0F);
        push_cmd(4'h4, 32'hFF00FF00, 32'h0F0F0F0F);
        push_cmd(4'h5, 32'hFF00FF00, 32'h0F0F0F0F);
        push_cmd(4'hE, 32'hFF00FF00, 32'h0F0F0F0F);
        push_cmd(4'hD, 32'h1, 32'h2);
        push_cmd(4'hE, 32'hA, 32'h4);
        repeat (40) tick();
        chk("t2.issued_stall", 128'(issued_cnt), 5);
        chk("t2.cmd_ready", 128'(cmd_ready), 1);
        chk("t2.busy", 128'(busy), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (alu_op_start)
                n++;
            tick();
        end
        chk("t2.no_start", 128'(n), 0);
        pop_chk("t2.and", 4'h3, 1'b0, 32'h0, 32'h0F000F00);
        pop_chk("t2.or", 4'h4, 1'b0, 32'h0, 32'hFF0FFF0F);
        pop_chk("t2.xor", 4'h5, 1'b0, 32'h0, 32'hF00FF00F);
        pop_chk("t2.sub", 4'hE, 1'b0, 32'h0, 32'hEFF1EFF1);
        pop_chk("t2.add5", 4'hD, 1'b0, 32'h0, 32'h3);
        pop_chk("t2.sub6", 4'hE, 1'b0, 32'h0, 32'h6);
        repeat (6) tick();
        chk("t2.issued", 128'(issued_cnt), 7);

        // MUL: two clear cycles then start
        push_cmd(4'hF, 32'h00010000, 32'h00010000);
        tick();
        chk("t3.clr_e1", 128'({alu_op_clear, alu_op_start}), 128'(2'b10));
        tick();
        chk("t3.clr_e2", 128'({alu_op_clear, alu_op_start}), 128'(2'b10));
        tick();
        chk("t3.start_e3", 128'({alu_op_clear, alu_op_start}), 128'(2'b01));
        pop_chk("t3.mul", 4'hF, 1'b0, 32'h1, 32'h0);
        repeat (6) tick();

        // MUL timeout after 8 START cycles
        hang = 1'b1;
        push_cmd(4'hF, 32'h2, 32'h3);
        repeat (3) tick();
        n = 0;
        while (alu_op_start && n < 20) begin
            n++;
            tick();
        end
        chk("t4.start_cycles", 128'(n), 8);
        chk("t4.clr_pulse", 128'(alu_op_clear), 1);
        chk("t4.err_valid", 128'({res_valid, res_err}), 128'(2'b11));
        tick();
        chk("t4.clr_drop", 128'(alu_op_clear), 0);
        hang = 1'b0;
        pop_chk("t4.to", 4'hF, 1'b1, 32'h0, 32'h0);
        push_cmd(4'hD, 32'h7, 32'h8);
        pop_chk("t4.next", 4'hD, 1'b0, 32'h0, 32'hF);
        repeat (6) tick();
        chk("t4.issued", 128'(issued_cnt), 10);

        // Lingering done keeps the FSM in RECOVER
        extra = 3;
        push_cmd(4'hD, 32'h1, 32'h1);
        push_cmd(4'hE, 32'h5, 32'h2);
        tick();
        tick();
        chk("t5.valid_e3", 128'(res_valid), 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (alu_op_start)
                n++;
        end
        chk("t5.held_off", 128'(n), 0);
        tick();
        chk("t5.start_e9", 128'(alu_op_start), 1);
        extra = 0;
        pop_chk("t5.r1", 4'hD, 1'b0, 32'h0, 32'h2);
        pop_chk("t5.r2", 4'hE, 1'b0, 32'h0, 32'h3);
        repeat (6) tick();
        chk("t5.issued", 128'(issued_cnt), 12);

        // Reset during a hung MUL with two commands queued
        hang = 1'b1;
        push_cmd(4'hF, 32'h3, 32'h3);
        push_cmd(4'hD, 32'h1, 32'h1);
        push_cmd(4'hD, 32'h2, 32'h2);
        tick();
        tick();
        chk("t6.in_start", 128'(alu_op_start), 1);
        reset_n = 1'b0;
        #1;
        chk("t6.rst.alu", 128'({alu_op_code, alu_shift, alu_operand_1, alu_operand_2,
                                alu_op_start, alu_op_clear}), 0);
        chk("t6.rst.misc", 128'({cmd_ready, res_valid, busy, issued_cnt}),
            128'({1'b1, 1'b0, 1'b0, 16'h0}));
        tick();
        hang = 1'b0;
        reset_n = 1'b1;
        repeat (10) tick();
        chk("t6.after", 128'({cmd_ready, res_valid, busy, alu_op_start, issued_cnt}),
            128'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
